mem_bist_ctrl: RTL and testbench

//  Hardware initiator for the 1K x 8 RAM (cs/wr/addr/data_in/data_out port set); replaces bench-driven access.
//  On start: fills the first num_words locations with a deterministic pattern, reads them back in order, compares.

---
 rtl/mem_bist_ctrl_pkg.sv | 24 ++
 rtl/mem_bist_pattern.sv | 29 ++
 rtl/mem_bist_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_ctrl_pkg.sv
// ============================================================================
// Module : mem_bist_ctrl_pkg
// Brief  : State encodings and pattern-select codes shared by the BIST files.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD     = 3'd3,
        S_RD_CHK = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic PAT_DOUBLE = 1'b0;
    localparam logic PAT_INVERT = 1'b1;

endpackage : mem_bist_ctrl_pkg

`default_nettype wire

// File: rtl/mem_bist_pattern.sv
// ============================================================================
// Module : mem_bist_pattern
// Brief  : Combinational test-pattern generator: (2*addr) mod 2**DATA_W, or its inverse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bist_pattern
    import mem_bist_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              pattern_sel,
    output logic [DATA_W-1:0] data
);

    logic [ADDR_W:0]   w_dbl;
    logic [DATA_W-1:0] w_base;

    // Cast both truncates and zero-extends, so any DATA_W/ADDR_W pairing wraps cleanly.
    assign w_dbl  = {addr, 1'b0};
    assign w_base = DATA_W'(w_dbl);
    assign data   = (pattern_sel == PAT_DOUBLE) ? w_base : ~w_base;

endmodule : mem_bist_pattern

`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
// ============================================================================
// Module : mem_bist_ctrl
// Brief  : Write-then-read-back RAM self test with error count and first failing address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bist_ctrl
    import mem_bist_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                r_sel;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W:0]     r_err_count;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic                r_pass;
    logic                r_done;
    logic                r_busy;
    logic                r_mem_cs;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [ADDR_W:0]     w_n_clamp;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W-1:0]   w_pat_addr;
    logic                w_pat_sel;
    logic [DATA_W-1:0]   w_pat;
    logic                w_mismatch;
    logic [ADDR_W:0]     w_err_next;
    logic                w_last;

    assign w_n_clamp  = (num_words > c_depth) ? c_depth : num_words;
    assign w_addr_inc = r_addr + 1'b1;
    assign w_last     = (r_addr == r_last_addr);
    assign w_pat_sel  = (r_state == S_IDLE) ? pattern_sel : r_sel;

    // One generator serves both directions: the next write address, or the address being checked.
    always_comb begin
        w_pat_addr = r_addr;
        if (r_state == S_IDLE) begin
            w_pat_addr = '0;
        end else if (r_state == S_WR_GAP) begin
            w_pat_addr = w_addr_inc;
        end
    end

    mem_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .addr        (w_pat_addr),
        .pattern_sel (w_pat_sel),
        .data        (w_pat)
    );

    assign w_mismatch = (r_state == S_RD_CHK) && (r_rdata != w_pat);
    assign w_err_next = r_err_count + (ADDR_W+1)'(w_mismatch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_addr           <= '0;
            r_last_addr      <= '0;
            r_sel            <= 1'b0;
            r_rdata          <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
            r_done           <= 1'b0;
            r_busy           <= 1'b0;
            r_mem_cs         <= 1'b0;
            r_mem_wr         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel            <= pattern_sel;
                        r_addr           <= '0;
                        r_last_addr      <= ADDR_W'(w_n_clamp - 1'b1);
                        r_err_count      <= '0;
                        r_first_err_addr <= '0;
                        r_pass           <= 1'b0;
                        if (w_n_clamp == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_WR;
                            r_busy      <= 1'b1;
                            r_mem_cs    <= 1'b1;
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= '0;
                            r_mem_wdata <= w_pat;
                        end
                    end
                end
                S_WR: begin
                    r_state <= S_WR_GAP;
                end
                S_WR_GAP: begin
                    if (w_last) begin
                        r_addr     <= '0;
                        r_state    <= S_RD;
                        r_mem_cs   <= 1'b1;
                        r_mem_addr <= '0;
                    end else begin
                        r_addr      <= w_addr_inc;
                        r_state     <= S_WR;
                        r_mem_cs    <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= w_addr_inc;
                        r_mem_wdata <= w_pat;
                    end
                end
                S_RD: begin
                    r_rdata <= mem_rdata;
                    r_state <= S_RD_CHK;
                end
                S_RD_CHK: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && (r_err_count == '0)) begin
                        r_first_err_addr <= r_addr;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_addr     <= w_addr_inc;
                        r_state    <= S_RD;
                        r_mem_cs   <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign mem_cs         = r_mem_cs;
    assign mem_wr         = r_mem_wr;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;

endmodule : mem_bist_ctrl

`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
// ============================================================================
// Module : tb_mem_bist_ctrl
// Brief  : Scoreboard bench for mem_bist_ctrl with a behavioural 1K x 8 RAM and bit-7 fault option.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_bist_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic              pattern_sel;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic              mem_cs;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_bist_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_words      (num_words),
        .pattern_sel    (pattern_sel),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem_cs         (mem_cs),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM; fault_b7 models bit 7 stuck at 0
    logic [DATA_W-1:0] ram [DEPTH];
    bit fault_b7 = 1'b0;
    always @(posedge clk) begin
        if (mem_cs && mem_wr) ram[mem_addr] <= fault_b7 ? (mem_wdata & 8'h7F) : mem_wdata;
    end
    assign mem_rdata = (mem_cs && !mem_wr) ? ram[mem_addr] : '0;

    typedef struct {
        int start_cyc;
        int n;
        bit pass;
        int err;
        int first;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   wr_idx      = 0;
    int   rd_idx      = 0;
    bit   cur_sel     = 1'b0;
    bit   prev_cs     = 1'b0;

    function automatic int ref_pat(int a, bit sel);
        int d;
        d = (2 * a) % 256;
        return sel ? (255 - d) : d;
    endfunction

    // Reference: what a full write pass then read pass over the (possibly faulty) RAM yields
    function automatic exp_t model(int nw, bit sel, bit fault);
        exp_t e;
        int   stored;
        e.n     = (nw > DEPTH) ? DEPTH : nw;
        e.err   = 0;
        e.first = 0;
        for (int a = 0; a < e.n; a++) begin
            stored = ref_pat(a, sel);
            if (fault) stored = stored % 128;
            if (stored != ref_pat(a, sel)) begin
                if (e.err == 0) e.first = a;
                e.err++;
            end
        end
        e.pass      = (e.err == 0);
        e.start_cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol and write/read ordering each cycle, results on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_cs = 1'b0;
        end else begin
            if (mem_cs) check("cs_back_to_back", int'(prev_cs), 0);
            if (mem_wr) check("wr_without_cs", int'(mem_cs), 1);
            if (mem_cs && mem_wr) begin
                check("wr_addr", int'(mem_addr), wr_idx);
                check("wr_data", int'(mem_wdata), ref_pat(wr_idx, cur_sel));
                wr_idx++;
            end else begin
                check("wdata_idle", int'(mem_wdata), 0);
            end
            if (mem_cs && !mem_wr) begin
                check("rd_addr", int'(mem_addr), rd_idx);
                rd_idx++;
            end
            prev_cs = mem_cs;
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - e.start_cyc, 4 * e.n);
                    check("pass", int'(pass), int'(e.pass));
                    check("err_count", int'(err_count), e.err);
                    check("first_err_addr", int'(first_err_addr), e.first);
                    check("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    task automatic run(input int nw, input bit sel, input bit fault, input bit poke_busy);
        exp_t e;
        int   budget;
        @(negedge clk);
        fault_b7    = fault;
        start       = 1'b1;
        num_words   = (ADDR_W+1)'(nw);
        pattern_sel = sel;
        wr_idx      = 0;
        rd_idx      = 0;
        cur_sel     = sel;
        @(posedge clk);
        #1;
        start       = 1'b0;
        num_words   = (ADDR_W+1)'($urandom_range(0, 2047));
        pattern_sel = ~sel;
        e           = model(nw, sel, fault);
        e.start_cyc = cyc;
        sb.push_back(e);
        if (poke_busy) begin
            repeat (10) @(posedge clk);
            #1;
            start     = 1'b1;
            num_words = (ADDR_W+1)'(5);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        budget = 4 * e.n + 20;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_mid_test();
        int guard;
        @(negedge clk);
        fault_b7    = 1'b0;
        start       = 1'b1;
        num_words   = (ADDR_W+1)'(16);
        pattern_sel = 1'b0;
        wr_idx      = 0;
        rd_idx      = 0;
        cur_sel     = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(mem_cs && mem_wr && mem_addr == 10'd7) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reach_wr_addr7", guard < 100 ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_cs", int'(mem_cs), 0);
        check("rst_mid_wr", int'(mem_wr), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_err", int'(err_count), 0);
        check("rst_mid_pass", int'(pass), 0);
        check("rst_mid_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_words   = '0;
        pattern_sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_first", int'(first_err_addr), 0);
        check("rst_cs", int'(mem_cs), 0);
        check("rst_wr", int'(mem_wr), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run(16, 1'b0, 1'b0, 1'b0);
        check("ram15_n16", int'(ram[15]), 30);
        run(1024, 1'b0, 1'b0, 1'b0);
        check("ram200", int'(ram[200]), 144);
        check("ram1023", int'(ram[1023]), 254);
        run(128, 1'b0, 1'b1, 1'b0);
        run(4, 1'b1, 1'b0, 1'b0);
        check("ram3_inv", int'(ram[3]), 8'hF9);
        run(0, 1'b0, 1'b0, 1'b0);
        run(2000, 1'b0, 1'b0, 1'b1);
        reset_mid_test();
        run(16, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run(int'($urandom_range(1, 300)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_bist_ctrl

`default_nettype wire
